// File: rtl/mc_core_pkg.sv
// mc_core_pkg: shared encodings and decode helpers for the mc_core_p multi-cycle core.
// Contents: opcode/funct localparams, FSM state enum, ALU op enum, instruction decode
// struct and helper functions. No ports.
package mc_core_pkg;

    localparam logic [5:0] OP_ALU   = 6'd0;
    localparam logic [5:0] OP_JMP   = 6'd2;
    localparam logic [5:0] OP_JEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LOAD  = 6'd32;
    localparam logic [5:0] OP_STORE = 6'd40;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_XOR = 6'd38;
    localparam logic [5:0] FN_SLT = 6'd42;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } mc_state_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_NOP
    } alu_op_e;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [31:0] imm32;   // sign-extended immediate, callers truncate
    } instr_dec_t;

    // Slice every field out of a fetched instruction word
    function automatic instr_dec_t f_decode(input logic [31:0] ir);
        instr_dec_t d;
        d.op    = ir[31:26];
        d.rs    = ir[25:21];
        d.rt    = ir[20:16];
        d.rd    = ir[15:11];
        d.funct = ir[5:0];
        d.imm32 = {{16{ir[15]}}, ir[15:0]};
        return d;
    endfunction

    function automatic logic f_funct_legal(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic f_op_legal(input logic [5:0] op);
        case (op)
            OP_ALU, OP_JMP, OP_JEQ, OP_ADDI, OP_LOAD, OP_STORE: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

    // ADDI reuses the adder; anything without a write-back maps to NOP
    function automatic alu_op_e f_alu_op(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_ADDI) return ALU_ADD;
        if (op != OP_ALU)  return ALU_NOP;
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_XOR:  return ALU_XOR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: NREGS x DATA_W register file, r0 hard-wired to zero.
// Ports: clk_i, reset_i (sync, active-high, clears all registers),
//        ra_i/rb_i -> rdata_a_o/rdata_b_o (asynchronous reads),
//        we_i/wa_i/wd_i (synchronous write, writes to r0 dropped).
module mc_regfile #(
    parameter int unsigned  DATA_W = 8,
    parameter int unsigned  NREGS  = 8,
    localparam int unsigned IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [IDX_W-1:0]  ra_i,
    input  logic [IDX_W-1:0]  rb_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [DATA_W-1:0] regs_q [NREGS];

    // r0 is cleared by reset and never written, so it always reads zero
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rdata_a_o = regs_q[ra_i];
    assign rdata_b_o = regs_q[rb_i];

endmodule

// File: rtl/mc_core_p.sv
// mc_core_p: parametrised multi-cycle MIPS-subset core with a request/grant bus.
// Ports: clk, reset (sync, active-high), grant_given (beat complete), grant_request,
//        rw (1 = write), address (MSB = GPIO select), data_in, data_out,
//        trap (sticky illegal-instruction flag, only when MC_CORE_TRAP_EN is defined).
// Build option: define MC_CORE_TRAP_EN to halt on illegal encodings instead of NOPing.
module mc_core_p
    import mc_core_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              grant_given,
    output logic              grant_request,
    output logic              rw,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
`ifdef MC_CORE_TRAP_EN
    ,
    output logic              trap
`endif
);

    localparam int unsigned IB    = 32 / DATA_W;
    localparam int unsigned CNT_W = (IB > 1) ? $clog2(IB) : 1;
    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned PC_W  = ADDR_W - 1;
    localparam int unsigned SUM_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

    mc_state_e         state_q;
    logic [PC_W-1:0]   pc_q;
    logic [31:0]       ir_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] res_q;

    instr_dec_t        dec_c;
    logic [IDX_W-1:0]  ra_c, rb_c, wa_c;
    logic [DATA_W-1:0] rs_val_c, rt_val_c;
    logic [DATA_W-1:0] alu_b_c, alu_res_c;
    logic [ADDR_W-1:0] ea_c;
    logic [PC_W-1:0]   jeq_pc_c;
    logic              wb_valid_c, we_c;

    assign dec_c = f_decode(ir_q);
    assign ra_c  = IDX_W'(dec_c.rs);
    assign rb_c  = IDX_W'(dec_c.rt);
    assign wa_c  = (dec_c.op == OP_ALU) ? IDX_W'(dec_c.rd) : IDX_W'(dec_c.rt);

    mc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clk_i     (clk),
        .reset_i   (reset),
        .ra_i      (ra_c),
        .rb_i      (rb_c),
        .rdata_a_o (rs_val_c),
        .rdata_b_o (rt_val_c),
        .we_i      (we_c),
        .wa_i      (wa_c),
        .wd_i      (res_q)
    );

    // Combinational ALU; the B operand is the immediate for ADDI
    always_comb begin
        alu_b_c   = (dec_c.op == OP_ADDI) ? DATA_W'(dec_c.imm32) : rt_val_c;
        alu_res_c = '0;
        case (f_alu_op(dec_c.op, dec_c.funct))
            ALU_ADD: alu_res_c = rs_val_c + alu_b_c;
            ALU_SUB: alu_res_c = rs_val_c - alu_b_c;
            ALU_AND: alu_res_c = rs_val_c & alu_b_c;
            ALU_OR:  alu_res_c = rs_val_c | alu_b_c;
            ALU_XOR: alu_res_c = rs_val_c ^ alu_b_c;
            ALU_SLT: alu_res_c = ($signed(rs_val_c) < $signed(alu_b_c)) ? DATA_W'(1) : '0;
            default: alu_res_c = '0;
        endcase
    end

    // rs is zero-extended into the address space, then the sum wraps at ADDR_W
    assign ea_c     = ADDR_W'(SUM_W'(rs_val_c) + SUM_W'(dec_c.imm32));
    assign jeq_pc_c = pc_q + PC_W'(dec_c.imm32);

    assign wb_valid_c = (dec_c.op == OP_ADDI) || (dec_c.op == OP_LOAD) ||
                        ((dec_c.op == OP_ALU) && f_funct_legal(dec_c.funct));
    assign we_c       = (state_q == ST_WB) && wb_valid_c;

`ifdef MC_CORE_TRAP_EN
    logic trap_q;
    logic illegal_c;
    assign illegal_c = !f_op_legal(dec_c.op) ||
                       ((dec_c.op == OP_ALU) && !f_funct_legal(dec_c.funct));
    assign trap      = trap_q;
`endif

    // Every beat is one idle cycle (request raised) followed by the request phase,
    // so the mandatory gap after a completed beat falls out naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            res_q   <= '0;
`ifdef MC_CORE_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!req_q) begin
                        req_q  <= 1'b1;
                        rw_q   <= 1'b0;
                        addr_q <= {1'b0, pc_q};
                    end else if (grant_given) begin
                        req_q <= 1'b0;
                        ir_q  <= 32'({ir_q, data_in});  // big-endian shift-in
                        pc_q  <= pc_q + PC_W'(1);
                        if (cnt_q == CNT_W'(IB - 1)) begin
                            cnt_q   <= '0;
                            state_q <= ST_DECODE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DECODE: begin
`ifdef MC_CORE_TRAP_EN
                    if (illegal_c) begin
                        trap_q  <= 1'b1;
                        state_q <= ST_HALT;
                    end else begin
                        state_q <= ST_EXEC;
                    end
`else
                    state_q <= ST_EXEC;
`endif
                end
                ST_EXEC: begin
                    case (dec_c.op)
                        OP_JMP: begin
                            pc_q    <= ir_q[PC_W-1:0];
                            state_q <= ST_FETCH;
                        end
                        OP_JEQ: begin
                            if (rs_val_c == rt_val_c) pc_q <= jeq_pc_c;
                            state_q <= ST_FETCH;
                        end
                        OP_LOAD, OP_STORE: state_q <= ST_MEM;
                        default: begin
                            res_q   <= alu_res_c;
                            state_q <= ST_WB;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (!req_q) begin
                        req_q  <= 1'b1;
                        rw_q   <= (dec_c.op == OP_STORE);
                        addr_q <= ea_c;
                        if (dec_c.op == OP_STORE) dout_q <= rt_val_c;
                    end else if (grant_given) begin
                        req_q   <= 1'b0;
                        if (dec_c.op == OP_LOAD) res_q <= data_in;
                        state_q <= ST_WB;
                    end
                end
                ST_WB: state_q <= ST_FETCH;
`ifdef MC_CORE_TRAP_EN
                ST_HALT: state_q <= ST_HALT;
`endif
                default: begin
                    state_q <= ST_FETCH;
                    pc_q    <= '0;
                    cnt_q   <= '0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign grant_request = req_q;
    assign rw            = rw_q;
    assign address       = addr_q;
    assign data_out      = dout_q;

endmodule

// File: tb/tb_mc_core_p.sv
// tb_mc_core_p: directed bench for mc_core_p at DATA_W=8, NREGS=8, ADDR_W=9.
// Bus model: byte memory for fetches, GPIO reads return 0xA5, programmable stall
// on one address. A negedge monitor logs each beat start for in-order checking.
module tb_mc_core_p;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       grant_given;
    logic       grant_request;
    logic       rw;
    logic [8:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
`ifdef MC_CORE_TRAP_EN
    logic       trap;
`endif

    mc_core_p #(.DATA_W(8), .NREGS(8), .ADDR_W(9)) dut (
        .clk           (clk),
        .reset         (reset),
        .grant_given   (grant_given),
        .grant_request (grant_request),
        .rw            (rw),
        .address       (address),
        .data_in       (data_in),
        .data_out      (data_out)
`ifdef MC_CORE_TRAP_EN
        ,
        .trap          (trap)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rw;
        logic [31:0] dout;
        logic [31:0] cyc;
    } beat_t;

    logic [7:0]  mem [256];
    logic [8:0]  stall_addr = 9'h005;
    int          stall_len  = 7;
    int          stall_cnt  = 0;
    logic [31:0] cyc        = 0;
    logic        req_prev   = 1'b0;
    beat_t       beats[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] last_start  = 0;

    assign grant_given = grant_request && !((address == stall_addr) && (stall_cnt < stall_len));
    always_comb data_in = address[8] ? 8'hA5 : mem[address[7:0]];

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        stall_cnt <= (grant_request && !grant_given) ? stall_cnt + 1 : 0;
    end

    always @(negedge clk) begin
        if (grant_request && !req_prev)
            beats.push_back('{32'(address), 32'(rw), 32'(data_out), cyc});
        req_prev <= grant_request;
    end

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {6'd2, target[25:0]};
    endfunction

    task automatic put(input int a, input logic [31:0] w);
        mem[a]     = w[31:24];
        mem[a + 1] = w[23:16];
        mem[a + 2] = w[15:8];
        mem[a + 3] = w[7:0];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic pop(output beat_t b);
        int n = 0;
        while (beats.size() == 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (beats.size() == 0) begin
            miscompares++;
            $display("FAIL bus_timeout: no beat within 200 cycles at cycle %0d", cyc);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
        b = beats.pop_front();
    endtask

    // Four fetch beats of one instruction; delta = cycles since previous instruction start
    task automatic expect_instr(input int a, input int delta);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            pop(b);
            chk($sformatf("fetch%0d_addr", a), b.addr, 32'(a + i));
            chk($sformatf("fetch%0d_rw", a), b.rw, 32'd0);
            if (i == 0) begin
                if (delta > 0) chk($sformatf("cpi_at_%0d", a), b.cyc - last_start, 32'(delta));
                last_start = b.cyc;
            end
        end
    endtask

    task automatic expect_wr(input int a, input int d);
        beat_t b;
        pop(b);
        chk($sformatf("wr%0h_addr", a), b.addr, 32'(a));
        chk($sformatf("wr%0h_rw", a), b.rw, 32'd1);
        chk($sformatf("wr%0h_data", a), b.dout, 32'(d));
    endtask

    task automatic expect_rd(input int a);
        beat_t b;
        pop(b);
        chk($sformatf("rd%0h_addr", a), b.addr, 32'(a));
        chk($sformatf("rd%0h_rw", a), b.rw, 32'd0);
    endtask

    initial begin
        beat_t b;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        put(0,   enc_i(8, 0, 1, 5));          // ADDI r1,r0,5
        put(4,   enc_i(8, 0, 2, 3));          // ADDI r2,r0,3
        put(8,   enc_r(1, 2, 3, 34));         // SUB  r3,r1,r2
        put(12,  enc_i(40, 0, 3, 16'h0040));  // STORE r3 -> 0x040
        put(16,  enc_i(4, 1, 2, 8));          // JEQ r1,r2,+8 (not taken)
        put(20,  enc_i(4, 1, 1, 10));         // JEQ r1,r1,+10 -> 34
        put(34,  enc_j(60));                  // JMP 60
        put(60,  enc_i(4, 1, 1, 16'hFFF4));   // JEQ r1,r1,-12 -> 52
        put(52,  enc_i(8, 0, 4, 16'h007F));   // ADDI r4,r0,0x7F
        put(56,  enc_j(72));                  // JMP 72
        put(72,  enc_i(40, 4, 1, 16'h0081));  // STORE r1 -> 0x100 (GPIO)
        put(76,  enc_i(32, 4, 6, 16'h0081));  // LOAD r6 <- 0x100
        put(80,  enc_i(40, 0, 6, 16'h0041));  // STORE r6 -> 0x041
        put(84,  enc_r(6, 3, 7, 38));         // XOR r7,r6,r3
        put(88,  enc_i(40, 0, 7, 16'h0042));  // STORE r7 -> 0x042
        put(92,  enc_r(6, 1, 5, 42));         // SLT r5,r6,r1
        put(96,  enc_i(40, 0, 5, 16'h0043));  // STORE r5 -> 0x043
        put(100, 32'hFC00_0000);              // op 63: illegal
        put(104, enc_i(32, 0, 2, 16'h0044));  // LOAD r2 <- 0x044

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", 32'(grant_request), 32'd0);
        chk("rst_rw", 32'(rw), 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
`ifdef MC_CORE_TRAP_EN
        chk("rst_trap", 32'(trap), 32'd0);
`endif
        reset = 1'b0;

        expect_instr(0, 0);

        // Instruction at 4: beat 2 (address 5) is stalled for 7 cycles
        pop(b);
        chk("fetch4_addr", b.addr, 32'd4);
        chk("cpi_at_4", b.cyc - last_start, 32'd11);
        last_start = b.cyc;
        pop(b);
        chk("stall_beat_addr", b.addr, 32'd5);
        for (int i = 0; i < 7; i++) begin
            chk("stall_addr_stable", 32'(address), 32'd5);
            chk("stall_req_held", 32'(grant_request), 32'd1);
            @(negedge clk);
            #1;
        end
        pop(b);
        chk("fetch4_b2", b.addr, 32'd6);
        pop(b);
        chk("fetch4_b3", b.addr, 32'd7);
        stall_addr = 9'h044;
        stall_len  = 1000;

        expect_instr(8, 18);
        expect_instr(12, 11);
        expect_wr(12'h040, 2);
        expect_instr(16, 13);
        expect_instr(20, 10);
        expect_instr(34, 10);
        expect_instr(60, 10);
        expect_instr(52, 10);
        expect_instr(56, 11);
        expect_instr(72, 10);
        expect_wr(12'h100, 5);
        expect_instr(76, 13);
        expect_rd(12'h100);
        expect_instr(80, 13);
        expect_wr(12'h041, 8'hA5);
        expect_instr(84, 13);
        expect_instr(88, 11);
        expect_wr(12'h042, 8'hA7);
        expect_instr(92, 13);
        expect_instr(96, 11);
        expect_wr(12'h043, 1);
        expect_instr(100, 13);

`ifdef MC_CORE_TRAP_EN
        repeat (20) @(negedge clk);
        #1;
        chk("halt_trap", 32'(trap), 32'd1);
        chk("halt_no_beats", 32'(beats.size()), 32'd0);
        chk("halt_req", 32'(grant_request), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("trap_cleared", 32'(trap), 32'd0);
`else
        expect_instr(104, 11);
        expect_rd(12'h044);
        // Stalled LOAD beat: reset while the request is pending
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_req", 32'(grant_request), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_mid_addr", 32'(address), 32'd0);
        chk("rst_mid_dout", 32'(data_out), 32'd0);
`endif
        stall_addr = 9'h1FF;
        beats.delete();
        reset = 1'b0;

        expect_instr(0, 0);
        expect_instr(4, 11);
        expect_instr(8, 11);
        expect_instr(12, 11);
        expect_wr(12'h040, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
